// File: rtl/minibyte_pkg.sv
// Shared types and constants for the minibyte memory responder.
package minibyte_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] ADDR_GPIO_IN  = 8'hFE;
  localparam logic [DATA_W-1:0] ADDR_GPIO_OUT = 8'hFF;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

  function automatic logic addr_is_ram(input logic [DATA_W-1:0] addr, input int depth);
    return (int'(addr) < depth);
  endfunction

endpackage

// File: rtl/minibyte_mem_resp_if.sv
// CPU-side memory bus: address, write data, write enable and registered read data.
interface minibyte_mem_resp_if
  import minibyte_pkg::*;
;
  logic [DATA_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic              we_in;
  logic [DATA_W-1:0] data_out;

  modport master (output addr_in, output data_in, output we_in, input data_out);
  modport slave  (input addr_in, input data_in, input we_in, output data_out);
endinterface

// File: rtl/minibyte_ram.sv
// Single-port synchronous RAM with read-first behaviour and registered read data.
module minibyte_ram
  import minibyte_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read old contents before the write lands on the same address
  always_ff @(posedge clk_in) begin
    rdata <= mem[addr];
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/minibyte_mem_resp.sv
// Memory-side responder: RAM, GPIO register pair and a byte-stream loader that
// fills RAM from address 0 while holding the CPU in reset.
module minibyte_mem_resp
  import minibyte_pkg::*;
#(
  parameter int RAM_DEPTH = 128
) (
  input  logic               clk_in,
  input  logic               rst_in,
  minibyte_mem_resp_if.slave bus,
  input  logic [DATA_W-1:0]  gpio_in,
  output logic [DATA_W-1:0]  gpio_out,
  input  logic               ld_start_in,
  input  logic               ld_valid_in,
  input  logic [DATA_W-1:0]  ld_data_in,
  input  logic               ld_last_in,
  output logic               ld_ready_out,
  output logic               ld_ovf_out,
  output logic               cpu_hold_out
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam logic [DATA_W-1:0] PTR_LAST = DATA_W'(RAM_DEPTH - 1);

  ld_state_e         state_r;
  logic [DATA_W-1:0] ptr_r;
  logic              sel_ram_r;
  logic [DATA_W-1:0] misc_r;
  logic [DATA_W-1:0] sync1_r;
  logic [DATA_W-1:0] sync2_r;
  logic [AW-1:0]     ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              ram_we_s;
  logic [DATA_W-1:0] ram_rdata_s;
  logic              in_load_s;
  logic              cpu_ram_s;

  assign in_load_s = (state_r == LD_LOAD);
  assign cpu_ram_s = addr_is_ram(bus.addr_in, RAM_DEPTH);

  // RAM port ownership: loader during LOAD, CPU otherwise
  always_comb begin
    ram_addr_s  = bus.addr_in[AW-1:0];
    ram_wdata_s = bus.data_in;
    ram_we_s    = 1'b0;
    if (in_load_s) begin
      ram_addr_s  = ptr_r[AW-1:0];
      ram_wdata_s = ld_data_in;
      ram_we_s    = ld_valid_in;
    end else begin
      ram_we_s = bus.we_in & cpu_ram_s;
    end
  end

  minibyte_ram #(
    .DEPTH (RAM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_in (clk_in),
    .addr   (ram_addr_s),
    .wdata  (ram_wdata_s),
    .we     (ram_we_s),
    .rdata  (ram_rdata_s)
  );

  // Read-path select and non-RAM read data, aligned with the RAM read latency
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_ram_r <= 1'b0;
      misc_r    <= 8'h00;
    end else if (in_load_s) begin
      sel_ram_r <= 1'b0;
      misc_r    <= 8'h00;
    end else begin
      sel_ram_r <= cpu_ram_s;
      case (bus.addr_in)
        ADDR_GPIO_IN:  misc_r <= sync2_r;
        ADDR_GPIO_OUT: misc_r <= gpio_out;
        default:       misc_r <= 8'h00;
      endcase
    end
  end

  assign bus.data_out = sel_ram_r ? ram_rdata_s : misc_r;

  // GPIO input synchronizer and output register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1_r  <= 8'h00;
      sync2_r  <= 8'h00;
      gpio_out <= 8'h00;
    end else begin
      sync1_r <= gpio_in;
      sync2_r <= sync1_r;
      if (!in_load_s && bus.we_in && (bus.addr_in == ADDR_GPIO_OUT)) begin
        gpio_out <= bus.data_in;
      end
    end
  end

  // Loader FSM with registered ready/hold/overflow outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r      <= LD_IDLE;
      ptr_r        <= 8'h00;
      ld_ready_out <= 1'b0;
      ld_ovf_out   <= 1'b0;
      cpu_hold_out <= 1'b0;
    end else begin
      case (state_r)
        LD_IDLE: begin
          if (ld_start_in) begin
            state_r      <= LD_LOAD;
            ptr_r        <= 8'h00;
            ld_ovf_out   <= 1'b0;
            ld_ready_out <= 1'b1;
            cpu_hold_out <= 1'b1;
          end
        end
        LD_LOAD: begin
          if (ld_valid_in) begin
            ptr_r <= ptr_r + 8'd1;
            if (ld_last_in) begin
              state_r      <= LD_DONE;
              ld_ready_out <= 1'b0;
            end else if (ptr_r == PTR_LAST) begin
              state_r      <= LD_DONE;
              ld_ready_out <= 1'b0;
              ld_ovf_out   <= 1'b1;
            end
          end
        end
        LD_DONE: begin
          state_r      <= LD_IDLE;
          ld_ready_out <= 1'b0;
          cpu_hold_out <= 1'b0;
        end
        default: begin
          state_r      <= LD_IDLE;
          ld_ready_out <= 1'b0;
          cpu_hold_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minibyte_mem_resp.sv
// Self-checking bench for minibyte_mem_resp (default depth plus a depth-4 instance).
module tb_minibyte_mem_resp;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out_a, gpio_out_b;
  logic       ld_start_a, ld_valid_a, ld_last_a, ld_ready_a, ld_ovf_a, hold_a;
  logic [7:0] ld_data_a;
  logic       ld_start_b, ld_valid_b, ld_last_b, ld_ready_b, ld_ovf_b, hold_b;
  logic [7:0] ld_data_b;

  minibyte_mem_resp_if bus_a ();
  minibyte_mem_resp_if bus_b ();

  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got, exp;

  typedef struct packed {
    logic [7:0] a;
    logic       we;
    logic [7:0] d;
    logic       chk;
    logic [7:0] e;
  } op_t;

  always #5 clk_in = ~clk_in;

  minibyte_mem_resp #(.RAM_DEPTH(128)) u_dut (
    .clk_in (clk_in), .rst_in (rst_in), .bus (bus_a),
    .gpio_in (gpio_in), .gpio_out (gpio_out_a),
    .ld_start_in (ld_start_a), .ld_valid_in (ld_valid_a), .ld_data_in (ld_data_a),
    .ld_last_in (ld_last_a), .ld_ready_out (ld_ready_a), .ld_ovf_out (ld_ovf_a),
    .cpu_hold_out (hold_a)
  );

  minibyte_mem_resp #(.RAM_DEPTH(4)) u_small (
    .clk_in (clk_in), .rst_in (rst_in), .bus (bus_b),
    .gpio_in (gpio_in), .gpio_out (gpio_out_b),
    .ld_start_in (ld_start_b), .ld_valid_in (ld_valid_b), .ld_data_in (ld_data_b),
    .ld_last_in (ld_last_b), .ld_ready_out (ld_ready_b), .ld_ovf_out (ld_ovf_b),
    .cpu_hold_out (hold_b)
  );

  // Drive one CPU cycle on the main bus and wait until just after the edge
  task automatic drive_a(input logic [7:0] a, input logic we, input logic [7:0] d);
    @(negedge clk_in);
    bus_a.addr_in = a;
    bus_a.we_in   = we;
    bus_a.data_in = d;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    #23;
    total_cnt += 5;
    if (bus_a.data_out !== 8'h00) $display("FAIL rst_data_out: got %h expected 00", bus_a.data_out); else pass_cnt++;
    if (gpio_out_a !== 8'h00) $display("FAIL rst_gpio_out: got %h expected 00", gpio_out_a); else pass_cnt++;
    if (ld_ready_a !== 1'b0) $display("FAIL rst_ready: got %b expected 0", ld_ready_a); else pass_cnt++;
    if (ld_ovf_a !== 1'b0) $display("FAIL rst_ovf: got %b expected 0", ld_ovf_a); else pass_cnt++;
    if (hold_a !== 1'b0) $display("FAIL rst_hold: got %b expected 0", hold_a); else pass_cnt++;
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_ram();
    op_t ops[9];
    ops = '{'{8'h10, 1'b1, 8'h5A, 1'b0, 8'h00}, '{8'h10, 1'b0, 8'h00, 1'b1, 8'h5A},
            '{8'h80, 1'b0, 8'h00, 1'b1, 8'h00}, '{8'h80, 1'b1, 8'h99, 1'b0, 8'h00},
            '{8'h80, 1'b0, 8'h00, 1'b1, 8'h00}, '{8'h10, 1'b1, 8'h77, 1'b1, 8'h5A},
            '{8'h10, 1'b0, 8'h00, 1'b1, 8'h77}, '{8'h7F, 1'b1, 8'h3D, 1'b0, 8'h00},
            '{8'h7F, 1'b0, 8'h00, 1'b1, 8'h3D}};
    for (int i = 0; i < 9; i++) begin
      if (ops[i].chk) exp_q.push_back(ops[i].e);
      drive_a(ops[i].a, ops[i].we, ops[i].d);
      if (ops[i].chk) begin
        got = bus_a.data_out; exp = exp_q.pop_front(); total_cnt++;
        if (got !== exp) $display("FAIL ram_rd[%0d]: got %h expected %h", i, got, exp); else pass_cnt++;
      end
    end
  endtask

  task automatic test_gpio();
    op_t ops[4];
    exp_q.push_back(8'hC3);
    drive_a(8'hFF, 1'b1, 8'hC3);
    exp = exp_q.pop_front();
    drive_a(8'hFF, 1'b0, 8'h00);
    got = bus_a.data_out; total_cnt++;
    if (got !== exp) $display("FAIL gpio_out_rd: got %h expected %h", got, exp); else pass_cnt++;
    total_cnt++;
    if (gpio_out_a !== 8'hC3) $display("FAIL gpio_out_pin: got %h expected c3", gpio_out_a); else pass_cnt++;
    @(negedge clk_in);
    gpio_in = 8'h3C;
    repeat (2) @(posedge clk_in);
    ops = '{'{8'hFE, 1'b0, 8'h00, 1'b1, 8'h3C}, '{8'hFE, 1'b1, 8'h11, 1'b1, 8'h3C},
            '{8'hFE, 1'b0, 8'h00, 1'b1, 8'h3C}, '{8'hFD, 1'b0, 8'h00, 1'b1, 8'h00}};
    for (int i = 0; i < 4; i++) begin
      if (ops[i].chk) exp_q.push_back(ops[i].e);
      drive_a(ops[i].a, ops[i].we, ops[i].d);
      if (ops[i].chk) begin
        got = bus_a.data_out; exp = exp_q.pop_front(); total_cnt++;
        if (got !== exp) $display("FAIL gpio_rd[%0d]: got %h expected %h", i, got, exp); else pass_cnt++;
      end
    end
    total_cnt++;
    if (gpio_out_a !== 8'hC3) $display("FAIL gpio_out_kept: got %h expected c3", gpio_out_a); else pass_cnt++;
  endtask

  task automatic test_load();
    logic [7:0] bytes[3];
    bytes = '{8'h01, 8'h42, 8'h00};
    drive_a(8'h02, 1'b1, 8'hFF);
    bus_a.we_in = 1'b0;
    @(negedge clk_in);
    ld_start_a = 1'b1;
    @(posedge clk_in); #1;
    total_cnt += 2;
    if (ld_ready_a !== 1'b1) $display("FAIL load_ready_on: got %b expected 1", ld_ready_a); else pass_cnt++;
    if (hold_a !== 1'b1) $display("FAIL load_hold_on: got %b expected 1", hold_a); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      ld_start_a = 1'b0; ld_valid_a = 1'b1; ld_data_a = bytes[i]; ld_last_a = (i == 2);
      @(posedge clk_in); #1;
      total_cnt++;
      if (hold_a !== 1'b1) $display("FAIL load_hold[%0d]: got %b expected 1", i, hold_a); else pass_cnt++;
    end
    total_cnt++;
    if (ld_ready_a !== 1'b0) $display("FAIL load_done_ready: got %b expected 0", ld_ready_a); else pass_cnt++;
    @(negedge clk_in);
    ld_valid_a = 1'b0; ld_last_a = 1'b0;
    @(posedge clk_in); #1;
    total_cnt += 2;
    if (hold_a !== 1'b0) $display("FAIL load_hold_off: got %b expected 0", hold_a); else pass_cnt++;
    if (ld_ovf_a !== 1'b0) $display("FAIL load_ovf: got %b expected 0", ld_ovf_a); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(bytes[i]);
      drive_a(8'(i), 1'b0, 8'h00);
      got = bus_a.data_out; exp = exp_q.pop_front(); total_cnt++;
      if (got !== exp) $display("FAIL load_ram[%0d]: got %h expected %h", i, got, exp); else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    @(negedge clk_in);
    ld_start_b = 1'b1;
    @(posedge clk_in); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      ld_start_b = 1'b0; ld_valid_b = 1'b1; ld_data_b = 8'hA0 + 8'(i);
      #1;
      total_cnt++;
      if (ld_ready_b !== (i < 4)) $display("FAIL ovf_ready[%0d]: got %b expected %b", i, ld_ready_b, (i < 4)); else pass_cnt++;
      @(posedge clk_in);
    end
    #1;
    @(negedge clk_in);
    ld_valid_b = 1'b0;
    total_cnt += 2;
    if (ld_ovf_b !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", ld_ovf_b); else pass_cnt++;
    if (hold_b !== 1'b0) $display("FAIL ovf_hold: got %b expected 0", hold_b); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      bus_b.addr_in = 8'(i); bus_b.we_in = 1'b0;
      exp_q.push_back((i < 4) ? 8'hA0 + 8'(i) : 8'h00);
      @(posedge clk_in); #1;
      got = bus_b.data_out; exp = exp_q.pop_front(); total_cnt++;
      if (got !== exp) $display("FAIL ovf_ram[%0d]: got %h expected %h", i, got, exp); else pass_cnt++;
    end
    @(negedge clk_in);
    ld_start_b = 1'b1;
    @(posedge clk_in); #1;
    total_cnt++;
    if (ld_ovf_b !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", ld_ovf_b); else pass_cnt++;
    @(negedge clk_in);
    ld_start_b = 1'b0; ld_valid_b = 1'b1; ld_last_b = 1'b1; ld_data_b = 8'h5B;
    @(negedge clk_in);
    ld_valid_b = 1'b0; ld_last_b = 1'b0;
    repeat (2) @(posedge clk_in);
  endtask

  task automatic test_load_blocks_cpu();
    logic [7:0] cpu_a[3], ldb[3], ra[5], re[5];
    logic       cpu_we[3], st[3];
    cpu_a = '{8'h05, 8'hFF, 8'h05}; cpu_we = '{1'b1, 1'b1, 1'b0};
    ldb = '{8'h21, 8'h22, 8'h23};   st = '{1'b0, 1'b1, 1'b0};
    drive_a(8'h05, 1'b1, 8'h12);
    bus_a.we_in = 1'b0;
    @(negedge clk_in);
    ld_start_a = 1'b1;
    @(posedge clk_in); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      ld_start_a = st[i]; ld_valid_a = 1'b1; ld_data_a = ldb[i]; ld_last_a = (i == 2);
      bus_a.addr_in = cpu_a[i]; bus_a.we_in = cpu_we[i]; bus_a.data_in = (i == 0) ? 8'hEE : 8'h99;
      exp_q.push_back(8'h00);
      @(posedge clk_in); #1;
      got = bus_a.data_out; exp = exp_q.pop_front(); total_cnt++;
      if (got !== exp) $display("FAIL lock_data_out[%0d]: got %h expected %h", i, got, exp); else pass_cnt++;
    end
    total_cnt++;
    if (gpio_out_a !== 8'hC3) $display("FAIL lock_gpio_out: got %h expected c3", gpio_out_a); else pass_cnt++;
    @(negedge clk_in);
    ld_start_a = 1'b0; ld_valid_a = 1'b0; ld_last_a = 1'b0; bus_a.we_in = 1'b0;
    @(posedge clk_in);
    ra = '{8'h00, 8'h01, 8'h02, 8'h05, 8'hFF};
    re = '{8'h21, 8'h22, 8'h23, 8'h12, 8'hC3};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(re[i]);
      drive_a(ra[i], 1'b0, 8'h00);
      got = bus_a.data_out; exp = exp_q.pop_front(); total_cnt++;
      if (got !== exp) $display("FAIL lock_ram[%0d]: got %h expected %h", i, got, exp); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk_in);
    ld_start_a = 1'b1;
    @(posedge clk_in);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      ld_start_a = 1'b0; ld_valid_a = 1'b1; ld_data_a = (i == 0) ? 8'h55 : 8'h66;
      @(posedge clk_in);
    end
    @(negedge clk_in);
    ld_valid_a = 1'b0;
    #2 rst_in = 1'b0;
    #1;
    total_cnt += 5;
    if (ld_ready_a !== 1'b0) $display("FAIL mid_rst_ready: got %b expected 0", ld_ready_a); else pass_cnt++;
    if (hold_a !== 1'b0) $display("FAIL mid_rst_hold: got %b expected 0", hold_a); else pass_cnt++;
    if (bus_a.data_out !== 8'h00) $display("FAIL mid_rst_data: got %h expected 00", bus_a.data_out); else pass_cnt++;
    if (gpio_out_a !== 8'h00) $display("FAIL mid_rst_gpio: got %h expected 00", gpio_out_a); else pass_cnt++;
    if (ld_ovf_a !== 1'b0) $display("FAIL mid_rst_ovf: got %b expected 0", ld_ovf_a); else pass_cnt++;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    ld_valid_a = 1'b1; ld_data_a = 8'h77;
    @(negedge clk_in);
    ld_valid_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back((i == 0) ? 8'h55 : 8'h66);
      drive_a(8'(i), 1'b0, 8'h00);
      got = bus_a.data_out; exp = exp_q.pop_front(); total_cnt++;
      if (got !== exp) $display("FAIL mid_rst_ram[%0d]: got %h expected %h", i, got, exp); else pass_cnt++;
    end
  endtask

  initial begin
    gpio_in = 8'h00;
    bus_a.addr_in = 8'h00; bus_a.data_in = 8'h00; bus_a.we_in = 1'b0;
    bus_b.addr_in = 8'h00; bus_b.data_in = 8'h00; bus_b.we_in = 1'b0;
    ld_start_a = 1'b0; ld_valid_a = 1'b0; ld_last_a = 1'b0; ld_data_a = 8'h00;
    ld_start_b = 1'b0; ld_valid_b = 1'b0; ld_last_b = 1'b0; ld_data_b = 8'h00;
    test_reset();
    test_ram();
    test_gpio();
    test_load();
    test_overflow();
    test_load_blocks_cpu();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
